// File: rtl/joybus_ctrl_tx.sv
// joybus_ctrl_tx: Joybus pulse-width serializer driving the open-drain N64 controller line.
// Define JOYBUS_TX_COLLISION_CHK_EN to abort a frame when the line is held low at the end of a bit.
module joybus_ctrl_tx #(
  parameter int         TICKS_PER_US = 4,
  parameter int         STOP_US      = 1,
  parameter logic [7:0] IDLE_TH      = 8'd32,
  parameter logic [9:0] BUS_WAIT_TO  = 10'd1023
) (
  input  logic        CTRL_CLK,
  input  logic        CTRL_nRST,
  input  logic        CTRL_i,
  input  logic        start_i,
  input  logic [31:0] tx_data_i,
  input  logic [2:0]  tx_len_i,
  output logic        CTRL_drv_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);
  localparam int TW = $clog2(3 * TICKS_PER_US) + 1;
  localparam logic [TW-1:0] TK_1T   = TW'(TICKS_PER_US - 1);
  localparam logic [TW-1:0] TK_3T   = TW'(3 * TICKS_PER_US - 1);
  localparam logic [TW-1:0] TK_STOP = TW'(STOP_US * TICKS_PER_US - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BUS, S_BIT_LOW, S_BIT_HIGH, S_STOP_LOW
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   shift_q, shift_d;
  logic [5:0]    bits_q, bits_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    idle_q, idle_d;
  logic [9:0]    wait_q, wait_d;
  logic          sync1_q, sync2_q;
  logic          drv_q, drv_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          line_s;

  assign line_s = sync2_q;

  // Phase lengths are preloaded minus one: '1' is short-low/long-high, '0' the reverse.
  function automatic logic [TW-1:0] low_ticks(input logic b);
    return b ? TK_1T : TK_3T;
  endfunction

  function automatic logic [TW-1:0] high_ticks(input logic b);
    return b ? TK_3T : TK_1T;
  endfunction

  always_ff @(posedge CTRL_CLK or negedge CTRL_nRST) begin
    if (!CTRL_nRST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep the two flops a real shift chain.
      sync1_q <= CTRL_i;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves a latch behind.
    state_d = state_q;
    shift_d = shift_q;
    bits_d  = bits_q;
    tick_d  = tick_q;
    idle_d  = idle_q;
    wait_d  = wait_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && (tx_len_i != 3'd0)) begin
          shift_d = tx_data_i;
          bits_d  = (tx_len_i >= 3'd4) ? 6'd32 : {tx_len_i, 3'b000};
          idle_d  = 8'd0;
          wait_d  = 10'd0;
          busy_d  = 1'b1;
          state_d = S_WAIT_BUS;
        end
      end
      S_WAIT_BUS: begin
        idle_d = line_s ? idle_q + 8'd1 : 8'd0;
        wait_d = wait_q + 10'd1;
        if (line_s && (idle_q == IDLE_TH - 8'd1)) begin
          tick_d  = low_ticks(shift_q[31]);
          state_d = S_BIT_LOW;
        end else if (wait_q == BUS_WAIT_TO - 10'd1) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_BIT_LOW: begin
        if (tick_q == '0) begin
          tick_d  = high_ticks(shift_q[31]);
          state_d = S_BIT_HIGH;
        end else begin
          tick_d = tick_q - 1'b1;
        end
      end
      S_BIT_HIGH: begin
        if (tick_q != '0) begin
          tick_d = tick_q - 1'b1;
`ifdef JOYBUS_TX_COLLISION_CHK_EN
        end else if (!line_s) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
`endif
        end else begin
          shift_d = {shift_q[30:0], 1'b0};
          bits_d  = bits_q - 6'd1;
          if (bits_q == 6'd1) begin
            tick_d  = TK_STOP;
            state_d = S_STOP_LOW;
          end else begin
            tick_d  = low_ticks(shift_q[30]);
            state_d = S_BIT_LOW;
          end
        end
      end
      S_STOP_LOW: begin
        if (tick_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tick_d = tick_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    drv_d = (state_d == S_BIT_LOW) || (state_d == S_STOP_LOW);
  end

  always_ff @(posedge CTRL_CLK or negedge CTRL_nRST) begin
    if (!CTRL_nRST) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bits_q  <= '0;
      tick_q  <= '0;
      idle_q  <= '0;
      wait_q  <= '0;
      drv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bits_q  <= bits_d;
      tick_q  <= tick_d;
      idle_q  <= idle_d;
      wait_q  <= wait_d;
      drv_q   <= drv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign CTRL_drv_o = drv_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_joybus_ctrl_tx.sv
// tb_joybus_ctrl_tx: two transmitters (1 us and 2 us stop) on shared stimulus, checked
// cycle by cycle against a waveform computed from the Joybus timing rules.
module tb_joybus_ctrl_tx;
  localparam int T       = 4;
  localparam int IDLE_TH = 32;
  localparam int WAIT_TO = 1023;
  localparam int MAXC    = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_i = 1'b1;
  logic        start = 1'b0;
  logic [31:0] data = '0;
  logic [2:0]  len = '0;
  logic        drv1, busy1, done1, err1;
  logic        drv2, busy2, done2, err2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lo_from = -1;
  int lo_to = -1;

  logic       line_h [MAXC];
  logic [3:0] obs1   [MAXC];
  logic [3:0] obs2   [MAXC];
  logic [3:0] exp_v  [MAXC];

  joybus_ctrl_tx #(.TICKS_PER_US(T), .STOP_US(1)) u_dut1 (
    .CTRL_CLK(clk), .CTRL_nRST(rst_n), .CTRL_i(line_i), .start_i(start),
    .tx_data_i(data), .tx_len_i(len), .CTRL_drv_o(drv1), .busy_o(busy1),
    .done_o(done1), .err_o(err1));

  joybus_ctrl_tx #(.TICKS_PER_US(T), .STOP_US(2)) u_dut2 (
    .CTRL_CLK(clk), .CTRL_nRST(rst_n), .CTRL_i(line_i), .start_i(start),
    .tx_data_i(data), .tx_len_i(len), .CTRL_drv_o(drv2), .busy_o(busy2),
    .done_o(done2), .err_o(err2));

  always #10 clk = ~clk;

  // Edge k records the line value sampled at that edge; outputs after edge k land in obs[k].
  always @(posedge clk) begin
    if (cyc < MAXC) line_h[cyc] <= line_i;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (cyc > 0 && cyc <= MAXC) begin
      obs1[cyc-1] <= {drv1, busy1, done1, err1};
      obs2[cyc-1] <= {drv2, busy2, done2, err2};
    end
  end

  initial forever begin
    @(negedge clk);
    line_i = !(cyc >= lo_from && cyc <= lo_to);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected {drv,busy,done,err} from accept edge a; returns the last index filled.
  function automatic int model(int a, int ln, logic [31:0] d, int stop_us);
    int nb, run, s0, e, k, lo;
    nb  = (ln >= 4) ? 32 : 8 * ln;
    run = 0;
    s0  = -1;
    e   = -1;
    exp_v[a] = 4'b0100;
    for (int j = 1; j <= WAIT_TO; j++) begin
      run = line_h[a+j-2] ? run + 1 : 0;
      if (run == IDLE_TH) begin
        s0 = a + j;
        break;
      end
      exp_v[a+j] = 4'b0100;
    end
    if (s0 < 0) begin
      e = a + WAIT_TO;
      exp_v[e] = 4'b0001;
    end else begin
      k = s0;
      for (int b = 0; b < nb && e < 0; b++) begin
        lo = d[31-b] ? T : 3 * T;
        for (int t = 0; t < 4 * T; t++) exp_v[k+t] = (t < lo) ? 4'b1100 : 4'b0100;
        k += 4 * T;
`ifdef JOYBUS_TX_COLLISION_CHK_EN
        if (!line_h[k-2]) begin
          e = k;
          exp_v[e] = 4'b0001;
        end
`endif
      end
      if (e < 0) begin
        for (int t = 0; t < stop_us * T; t++) exp_v[k+t] = 4'b1100;
        e = k + stop_us * T;
        exp_v[e] = 4'b0010;
      end
    end
    for (int t = 1; t <= 4; t++) exp_v[e+t] = 4'b0000;
    return e + 4;
  endfunction

  task automatic compare(input string tag, input int a, input int last, input int which);
    for (int k = a; k <= last && k < MAXC; k++)
      check($sformatf("%s@%0d", tag, k), {28'd0, (which == 1) ? obs1[k] : obs2[k]},
            {28'd0, exp_v[k]});
  endtask

  task automatic start_frame(input int ln, input logic [31:0] d, output int a);
    @(negedge clk);
    start = 1'b1;
    len   = ln[2:0];
    data  = d;
    a     = cyc;
    @(negedge clk);
    start = 1'b0;
    len   = 3'($urandom);
    data  = $urandom;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy1 || busy2) && n < 1500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_bounded"}, 32'(busy1 | busy2), 32'd0);
    repeat (8) @(negedge clk);
  endtask

  task automatic verify(input string tag, input int a, input int ln, input logic [31:0] d);
    int last;
    last = model(a, ln, d, 1);
    compare({tag, "_s1"}, a, last, 1);
    last = model(a, ln, d, 2);
    compare({tag, "_s2"}, a, last, 2);
  endtask

  initial begin
    int a, ln;
    logic [31:0] d;

    repeat (3) @(negedge clk);
    check("rst_out1", {28'd0, drv1, busy1, done1, err1}, 32'd0);
    check("rst_out2", {28'd0, drv2, busy2, done2, err2}, 32'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    start_frame(1, 32'h0100_0000, a);
    wait_idle("t1");
    verify("t1", a, 1, 32'h0100_0000);

    start_frame(3, 32'h1DAA_5500, a);
    wait_idle("t2");
    verify("t2", a, 3, 32'h1DAA_5500);

    // Line held low for the whole bus wait: timeout error, no drive.
    lo_from = cyc;
    lo_to   = cyc + 1040;
    d = $urandom;
    start_frame(2, d, a);
    wait_idle("t3_to");
    verify("t3_to", a, 2, d);
    repeat (30) @(negedge clk);
    lo_from = -1;
    lo_to   = -1;
    repeat (40) @(negedge clk);

    d = $urandom;
    start_frame(1, d, a);
    lo_from = a + 20;
    lo_to   = a + 20;
    wait_idle("t3_glitch");
    verify("t3_glitch", a, 1, d);
    lo_from = -1;
    lo_to   = -1;

    // A second start while busy must not disturb the frame.
    d = $urandom;
    start_frame(2, d, a);
    repeat (50) @(negedge clk);
    start = 1'b1;
    len   = 3'd2;
    data  = ~d;
    @(negedge clk);
    start = 1'b0;
    wait_idle("t4_busy");
    verify("t4_busy", a, 2, d);

    @(negedge clk);
    start = 1'b1;
    len   = 3'd0;
    a     = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (44) @(negedge clk);
    for (int k = a; k < a + 40; k++) exp_v[k] = 4'b0000;
    compare("t4_len0_s1", a, a + 39, 1);
    compare("t4_len0_s2", a, a + 39, 2);

    d = $urandom;
    start_frame(7, d, a);
    wait_idle("t4_len7");
    verify("t4_len7", a, 7, d);

    // Asynchronous reset in the low phase of the first bit.
    d = $urandom;
    start_frame(1, d, a);
    while (cyc < a + 35) @(negedge clk);
    check("t5_drv_pre", 32'(drv1), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("t5_drv1_async", 32'(drv1), 32'd0);
    check("t5_drv2_async", 32'(drv2), 32'd0);
    check("t5_busy_async", 32'(busy1 | busy2), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    d = $urandom;
    start_frame(2, d, a);
    wait_idle("t5_after");
    verify("t5_after", a, 2, d);

    // Line pulled low during the high phase of bit 3.
    repeat (40) @(negedge clk);
    d = $urandom;
    start_frame(2, d, a);
    lo_from = a + 32 + 60;
    lo_to   = a + 32 + 63;
    wait_idle("t6_coll");
    verify("t6_coll", a, 2, d);
    lo_from = -1;
    lo_to   = -1;

    for (int i = 0; i < 6; i++) begin
      repeat (40) @(negedge clk);
      ln = $urandom_range(1, 7);
      d  = $urandom;
      start_frame(ln, d, a);
      if ($urandom_range(0, 1) == 1) begin
        lo_from = a + $urandom_range(0, 30);
        lo_to   = lo_from + $urandom_range(0, 2);
      end
      wait_idle($sformatf("rnd%0d", i));
      verify($sformatf("rnd%0d", i), a, ln, d);
      lo_from = -1;
      lo_to   = -1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
